// File: rtl/divider_pkg.sv
// Shared types and sizing helpers for the sequential signed divider.
// The optional divide-by-zero shortcut is enabled with SEQ_DIVIDER_ZERO_CHECK_EN.
package divider_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } div_state_t;

  localparam int DEFAULT_WIDTH = 8;

  // Step counter must be able to represent WIDTH.
  function automatic int step_cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/seq_signed_divider_if.sv
// Start/ready request and result bus of the sequential signed divider.
interface seq_signed_divider_if #(
  parameter int WIDTH = divider_pkg::DEFAULT_WIDTH
);

  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             ready;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             overflow;
  logic             div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  ready, done, quotient, remainder, overflow, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output ready, done, quotient, remainder, overflow, div_by_zero
  );

endinterface

// File: rtl/twos_complement_abs.sv
// Conditional two's-complement negate; yields |in| when sel is the sign bit.
module twos_complement_abs #(
  parameter int WIDTH = 8
) (
  input  logic             sel,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out
);

  assign out = sel ? (~in + WIDTH'(1)) : in;

endmodule

// File: rtl/seq_signed_divider.sv
// Iterative signed divider: one restoring step per clock on magnitudes, then sign fix-up.
// Define SEQ_DIVIDER_ZERO_CHECK_EN to short-circuit a zero divisor and raise div_by_zero.
module seq_signed_divider
  import divider_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input logic                 clk,
  input logic                 rst,
  seq_signed_divider_if.slave bus
);

  localparam int               CNT_W    = step_cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MIN_VAL  = {1'b1, {(WIDTH-1){1'b0}}};

  div_state_t       state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [WIDTH:0]   rem_reg;
  logic [WIDTH-1:0] dvd_reg;
  logic [WIDTH-1:0] dvs_reg;
  logic             q_sign_reg;
  logic             r_sign_reg;
  logic             ovf_pend_reg;

  logic             done_reg;
  logic [WIDTH-1:0] quotient_reg;
  logic [WIDTH-1:0] remainder_reg;
  logic             overflow_reg;

  logic [WIDTH-1:0] op_raw [2];
  logic [WIDTH-1:0] op_mag [2];
  logic [WIDTH-1:0] q_fixed;
  logic [WIDTH-1:0] r_fixed;
  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] diff;

  assign op_raw[0] = bus.dividend;
  assign op_raw[1] = bus.divisor;

  for (genvar gi = 0; gi < 2; gi++) begin : g_op_abs
    twos_complement_abs #(.WIDTH(WIDTH)) u_abs (
      .sel (op_raw[gi][WIDTH-1]),
      .in  (op_raw[gi]),
      .out (op_mag[gi])
    );
  end

  twos_complement_abs #(.WIDTH(WIDTH)) u_q_fix (
    .sel (q_sign_reg),
    .in  (dvd_reg),
    .out (q_fixed)
  );

  twos_complement_abs #(.WIDTH(WIDTH)) u_r_fix (
    .sel (r_sign_reg),
    .in  (rem_reg[WIDTH-1:0]),
    .out (r_fixed)
  );

  // The dividend register doubles as the quotient: its MSB shifts into the
  // partial remainder while the new quotient bit enters at the LSB.
  assign shifted = {rem_reg, dvd_reg[WIDTH-1]};
  assign diff    = shifted - {2'b00, dvs_reg};

`ifdef SEQ_DIVIDER_ZERO_CHECK_EN
  logic dbz_pend_reg;
  logic div_by_zero_reg;
  assign bus.div_by_zero = div_by_zero_reg;
`else
  assign bus.div_by_zero = 1'b0;
`endif

  assign bus.ready     = (state_reg == IDLE);
  assign bus.done      = done_reg;
  assign bus.quotient  = quotient_reg;
  assign bus.remainder = remainder_reg;
  assign bus.overflow  = overflow_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg       <= IDLE;
      cnt_reg         <= '0;
      rem_reg         <= '0;
      dvd_reg         <= '0;
      dvs_reg         <= '0;
      q_sign_reg      <= 1'b0;
      r_sign_reg      <= 1'b0;
      ovf_pend_reg    <= 1'b0;
      done_reg        <= 1'b0;
      quotient_reg    <= '0;
      remainder_reg   <= '0;
      overflow_reg    <= 1'b0;
`ifdef SEQ_DIVIDER_ZERO_CHECK_EN
      dbz_pend_reg    <= 1'b0;
      div_by_zero_reg <= 1'b0;
`endif
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (bus.start) begin
            q_sign_reg   <= bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
            r_sign_reg   <= bus.dividend[WIDTH-1];
            rem_reg      <= '0;
            dvd_reg      <= op_mag[0];
            dvs_reg      <= op_mag[1];
            cnt_reg      <= '0;
            ovf_pend_reg <= (bus.dividend == MIN_VAL) && (bus.divisor == '1);
            state_reg    <= CALC;
`ifdef SEQ_DIVIDER_ZERO_CHECK_EN
            dbz_pend_reg <= (bus.divisor == '0);
            // Preload FIX so it emits all-ones quotient and the dividend as remainder.
            if (bus.divisor == '0) begin
              q_sign_reg <= 1'b0;
              rem_reg    <= {1'b0, op_mag[0]};
              dvd_reg    <= '1;
              state_reg  <= FIX;
            end
`endif
          end
        end
        CALC: begin
          if (!diff[WIDTH+1]) begin
            rem_reg <= diff[WIDTH:0];
            dvd_reg <= {dvd_reg[WIDTH-2:0], 1'b1};
          end else begin
            rem_reg <= shifted[WIDTH:0];
            dvd_reg <= {dvd_reg[WIDTH-2:0], 1'b0};
          end
          cnt_reg <= cnt_reg + CNT_W'(1);
          if (cnt_reg == LAST_CNT) begin
            state_reg <= FIX;
          end
        end
        FIX: begin
          quotient_reg    <= q_fixed;
          remainder_reg   <= r_fixed;
          overflow_reg    <= ovf_pend_reg;
`ifdef SEQ_DIVIDER_ZERO_CHECK_EN
          div_by_zero_reg <= dbz_pend_reg;
`endif
          done_reg        <= 1'b1;
          state_reg       <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_signed_divider.sv
// Bench for seq_signed_divider: arithmetic reference model checked every cycle
// plus directed operations with hand-computed results and latencies.
module tb_seq_signed_divider;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  bit   checking = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   cycle = 0;
  int   txn = 0;

  seq_signed_divider_if #(.WIDTH(W)) bus ();

  seq_signed_divider #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  // Reference model: results from plain integer / and %, delivered after the latency.
  bit             m_busy = 1'b0;
  bit             m_done = 1'b0;
  int             m_left = 0;
  logic [W-1:0]   m_q = '0, m_r = '0, p_q = '0, p_r = '0;
  bit             m_ovf = 1'b0, m_dbz = 1'b0, p_ovf = 1'b0, p_dbz = 1'b0;

  task automatic model_op(input logic [W-1:0] dividend, input logic [W-1:0] divisor);
    int a;
    int b;
    int q;
    int r;
    a = int'($signed(dividend));
    b = int'($signed(divisor));
    p_ovf  = (a == -(1 << (W - 1))) && (b == -1);
    p_dbz  = 1'b0;
    m_left = W + 1;
    if (b == 0) begin
      r = a;
`ifdef SEQ_DIVIDER_ZERO_CHECK_EN
      q      = -1;
      p_dbz  = 1'b1;
      m_left = 1;
`else
      q = (a < 0) ? 1 : -1;
`endif
    end else begin
      q = a / b;
      r = a % b;
    end
    p_q    = q[W-1:0];
    p_r    = r[W-1:0];
    m_busy = 1'b1;
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy = 1'b0; m_done = 1'b0; m_left = 0;
      m_q = '0; m_r = '0; m_ovf = 1'b0; m_dbz = 1'b0;
    end else begin
      m_done = 1'b0;
      if (m_busy) begin
        m_left--;
        if (m_left == 0) begin
          m_busy = 1'b0; m_done = 1'b1;
          m_q = p_q; m_r = p_r; m_ovf = p_ovf; m_dbz = p_dbz;
        end
      end else if (bus.start) begin
        model_op(bus.dividend, bus.divisor);
      end
    end
  end

  always @(negedge clk) begin
    if (checking) begin
      chk("ready", bus.ready, !m_busy);
      chk("done", bus.done, m_done);
      chk("quotient", bus.quotient, m_q);
      chk("remainder", bus.remainder, m_r);
      chk("overflow", bus.overflow, m_ovf);
      chk("div_by_zero", bus.div_by_zero, m_dbz);
      if (m_done) begin
        txn++;
        $display("txn %0d: quotient=%h remainder=%h overflow=%0b div_by_zero=%0b (cycle %0d)",
                 txn, bus.quotient, bus.remainder, bus.overflow, bus.div_by_zero, cycle);
      end
    end
  end

  // Issue one operation and wait for done; returns at the negedge of the done cycle.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] eq, input logic [W-1:0] er,
                        input bit eovf, input bit edbz, input int elat,
                        input int inj, input string name);
    bit found;
    found = 1'b0;
    bus.start = 1'b1; bus.dividend = a; bus.divisor = b;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.dividend = W'($urandom); bus.divisor = W'($urandom);
    for (int n = 1; n <= 4 * W; n++) begin
      @(negedge clk);
      if (bus.done) begin
        chk({name, "_latency"}, n - 1, elat);
        found = 1'b1;
        break;
      end
      if (n == inj) begin
        bus.start = 1'b1; bus.dividend = 8'd50; bus.divisor = 8'd5;
      end else begin
        bus.start = 1'b0;
      end
    end
    bus.start = 1'b0;
    if (!found) begin
      checks++; errors++;
      $display("FAIL %s_timeout actual=no_done required=done", name);
    end else begin
      chk({name, "_q"}, bus.quotient, eq);
      chk({name, "_r"}, bus.remainder, er);
      chk({name, "_ovf"}, bus.overflow, eovf);
      chk({name, "_dbz"}, bus.div_by_zero, edbz);
    end
  endtask

  initial begin
    int dones;
    int zlat;
    bit zdbz;
    logic [W-1:0] zq_neg;
`ifdef SEQ_DIVIDER_ZERO_CHECK_EN
    zlat = 1; zdbz = 1'b1; zq_neg = 8'hFF;
`else
    zlat = W + 1; zdbz = 1'b0; zq_neg = 8'h01;
`endif
    bus.start = 1'b0; bus.dividend = '0; bus.divisor = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checking = 1'b1;
    chk("reset_ready", bus.ready, 1'b1);
    chk("reset_done", bus.done, 1'b0);
    chk("reset_q", bus.quotient, 8'h00);
    chk("reset_r", bus.remainder, 8'h00);
    rst = 1'b0;
    @(negedge clk);

    run_op(8'd100, 8'd7, 8'h0E, 8'h02, 1'b0, 1'b0, 9, 0, "p100_p7");
    run_op(-8'sd100, 8'd7, 8'hF2, 8'hFE, 1'b0, 1'b0, 9, 0, "n100_p7");
    run_op(8'd100, -8'sd7, 8'hF2, 8'h02, 1'b0, 1'b0, 9, 0, "p100_n7");
    run_op(8'h80, 8'hFF, 8'h80, 8'h00, 1'b1, 1'b0, 9, 0, "min_neg1");
    run_op(8'd5, 8'd3, 8'h01, 8'h02, 1'b0, 1'b0, 9, 0, "p5_p3");
    run_op(8'd7, 8'd0, 8'hFF, 8'h07, 1'b0, zdbz, zlat, 0, "p7_zero");
    run_op(-8'sd7, 8'd0, zq_neg, 8'hF9, 1'b0, zdbz, zlat, 0, "n7_zero");
    run_op(8'd100, 8'd7, 8'h0E, 8'h02, 1'b0, 1'b0, 9, 4, "busy_start");
    run_op(-8'sd50, 8'd6, 8'hF8, 8'hFE, 1'b0, 1'b0, 9, 0, "n50_p6");

    // Abort 100 / 7 after four division steps.
    bus.start = 1'b1; bus.dividend = 8'd100; bus.divisor = 8'd7;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort_ready", bus.ready, 1'b1);
    chk("abort_done", bus.done, 1'b0);
    chk("abort_q", bus.quotient, 8'h00);
    chk("abort_r", bus.remainder, 8'h00);
    chk("abort_ovf", bus.overflow, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    dones = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus.done) dones++;
    end
    chk("abort_no_done", dones, 0);

    run_op(8'd20, 8'd4, 8'h05, 8'h00, 1'b0, 1'b0, 9, 0, "p20_p4");
    run_op(8'h80, 8'd1, 8'h80, 8'h00, 1'b0, 1'b0, 9, 0, "min_p1");
    run_op(8'd127, 8'h80, 8'h00, 8'h7F, 1'b0, 1'b0, 9, 0, "max_min");
    run_op(8'h80, 8'h80, 8'h01, 8'h00, 1'b0, 1'b0, 9, 0, "min_min");
    run_op(8'd0, 8'd5, 8'h00, 8'h00, 1'b0, 1'b0, 9, 0, "zero_p5");
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/seq_signed_divider.md
# seq_signed_divider

- Iterative signed two's-complement divider; the inverse datapath to the team's signed half-split multiplier.
- Takes a WIDTH-bit dividend and divisor on a start/ready handshake.
- Runs one restoring-division step per clock on operand magnitudes, applies a sign fix-up, and presents quotient and remainder with a one-cycle done pulse.
- Sits beside the multiplier in the arithmetic datapath wherever a quotient or remainder is needed and multi-cycle latency is acceptable.

## Interface
- WIDTH, 8, operand/result width in bits; even, ≥4.
- clk  input  1  sole clock, rising edge.
- rst  input  1  reset; asynchronous, active-high.
- start  input  1  request; sampled only when ready=1.
- dividend  input  WIDTH  signed two's-complement dividend; captured with start.
- divisor  input  WIDTH  signed two's-complement divisor; captured with start.
- ready  output  1  high in IDLE; combinational from state.
- done  output  1  one-cycle pulse; results valid.
- quotient  output  WIDTH  signed quotient; held until the next done.
- remainder  output  WIDTH  signed remainder; held until the next done.
- overflow  output  1  set with done for the only unrepresentable case: -2^(WIDTH-1) / -1.
- div_by_zero  output  1  set with done when divisor==0; tied 0 if SEQ_DIVIDER_ZERO_CHECK_EN is undefined.

## Operation
- States: IDLE, CALC, FIX.
- IDLE, start=1 at edge E0:
  - Latch the sign bits of both operands.
  - Load magnitudes |dividend| and |divisor| as WIDTH-bit unsigned values (|-2^(WIDTH-1)| = 2^(WIDTH-1)).
  - Clear the WIDTH+1-bit partial remainder and the step counter.
  - Go to CALC.
- CALC, one step per edge:
  - Shift {partial remainder, dividend magnitude} left by 1.
  - Trial-subtract the divisor magnitude.
  - If non-negative, keep the difference and shift in quotient bit 1; otherwise restore and shift in 0.
  - After WIDTH steps, go to FIX.
- FIX, one edge:
  - Quotient sign = dividend sign XOR divisor sign; remainder sign = dividend sign.
  - Negate the magnitudes where the sign is 1, truncated to WIDTH bits.
  - Results truncate toward zero, matching Verilog / and %.
  - Register quotient, remainder and flags; pulse done; return to IDLE.
- overflow: dividend = 0x80..0 and divisor = all ones. quotient = 0x80..0 (wrapped), remainder = 0, overflow = 1.
- Flags are registered with done and hold until the next done.
- start while busy (not IDLE) is ignored; no queueing.
- Reset mid-operation: abort immediately; no done pulse; return to IDLE.
- Reset values: done=0, quotient=0, remainder=0, overflow=0, div_by_zero=0, state IDLE, so ready=1.

## Timing
- Latency: start sampled at E0 → done high for the cycle after edge E0+WIDTH+1 (WIDTH+1 clocks; 9 at WIDTH=8).
- Throughput: start may be asserted during the done cycle (ready=1), so back-to-back operations run every WIDTH+1 cycles.
- ready falls the cycle after start is accepted and rises together with done.
- Operand inputs are don't-care after E0.

## Configuration
- SEQ_DIVIDER_ZERO_CHECK_EN defined:
  - At E0, divisor==0 bypasses CALC and goes straight to FIX.
  - Outputs: quotient = all ones, remainder = dividend, div_by_zero = 1.
  - done arrives 1 cycle after E0.
- Undefined:
  - No check; the algorithm runs normally with latency WIDTH+1.
  - Magnitude quotient is all ones, sign fix-up applied: dividend 7 → quotient 0xFF, remainder 7; dividend -7 → quotient 0x01, remainder 0xF9.
  - div_by_zero is constant 0.

## Structure
- Package divider_pkg holds:
  - the state typedef (IDLE, CALC, FIX);
  - the default WIDTH localparam;
  - the step-counter width $clog2(WIDTH+1).
- Sub-module twos_complement_abs: conditional negate, `out = sel ? ~in + 1 : in`. Instantiated for each operand magnitude and for each FIX negation.
- Counter, partial remainder and FSM stay in the top module.

## Test plan
- 100 / 7 → quotient 14 (0x0E), remainder 2; done exactly 9 cycles after start at WIDTH=8; ready low in between.
- -100 / 7 → quotient 0xF2 (-14), remainder 0xFE (-2); 100 / -7 → quotient 0xF2, remainder 0x02.
- -128 / -1 → quotient 0x80, remainder 0, overflow=1; next op 5 / 3 → quotient 1, remainder 2, overflow=0.
- 7 / 0 with SEQ_DIVIDER_ZERO_CHECK_EN → quotient 0xFF, remainder 7, div_by_zero=1, done 1 cycle after start. Without the macro → quotient 0xFF, remainder 7, done after 9 cycles.
- Pulse start during CALC with other operands → ignored, first result unchanged. Then start in the done cycle → second result 9 cycles later.
- Assert rst at step 4 of 100 / 7 → no done, all outputs 0, ready=1. A following 20 / 4 → quotient 5, remainder 0.
